multdiv_issue: RTL and testbench

MULTDIV_ISSUE -- requirements
Module: multdiv_issue

---
 rtl/multdiv_issue_pkg.sv | 15 +
 rtl/multdiv_issue.sv | 140 ++++++++++++++
 tb/tb_multdiv_issue.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_issue_pkg.sv
// Shared types and constants for the mult/div issue sequencer.
package multdiv_issue_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } md_state_t;

  localparam logic [31:0] EXC_CODE_MULT       = 32'd4;
  localparam logic [31:0] EXC_CODE_DIV        = 32'd5;
  localparam int          DEFAULT_RSTATUS_REG = 30;

endpackage

// File: rtl/multdiv_issue.sv
// Sequences one decoded mult/div request through the external multdiv unit and writeback.
// Optional WAIT watchdog is enabled by defining MD_TIMEOUT_EN.
module multdiv_issue
  import multdiv_issue_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int RSTATUS_REG    = DEFAULT_RSTATUS_REG
) (
  input  logic        clock,
  input  logic        clrn,
  input  logic        in_valid,
  input  logic        in_isMult,
  input  logic [31:0] in_opA,
  input  logic [31:0] in_opB,
  input  logic [4:0]  in_rd,
  output logic        stall,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  input  logic [31:0] data_result,
  input  logic        data_exception,
  input  logic        data_resultRDY,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        wb_ready
);

  md_state_t   state_q, state_d;
  logic        op_is_mult_q;
  logic [31:0] op_a_q, op_b_q;
  logic [4:0]  rd_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        latch_op, capture, capture_exc, timeout_hit;

`ifdef MD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;

  // Counts completed WAIT cycles; the last allowed WAIT cycle fires the timeout.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      wait_cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      wait_cnt_q <= '0;
    end else if (state_q == WAIT) begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end

  assign timeout_hit = (state_q == WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    latch_op    = 1'b0;
    capture     = 1'b0;
    capture_exc = 1'b0;
    ctrl_MULT   = 1'b0;
    ctrl_DIV    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          latch_op = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        ctrl_MULT = op_is_mult_q;
        ctrl_DIV  = !op_is_mult_q;
        state_d   = WAIT;
      end
      WAIT: begin
        // A real result always beats a watchdog expiring in the same cycle.
        if (data_resultRDY) begin
          capture     = 1'b1;
          capture_exc = data_exception;
          state_d     = (!data_exception && rd_q == 5'd0) ? IDLE : WB;
        end else if (timeout_hit) begin
          capture     = 1'b1;
          capture_exc = 1'b1;
          state_d     = WB;
        end
      end
      WB: begin
        if (wb_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      op_is_mult_q <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      rd_q         <= '0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
    end else begin
      if (latch_op) begin
        op_is_mult_q <= in_isMult;
        op_a_q       <= in_opA;
        op_b_q       <= in_opB;
        rd_q         <= in_rd;
      end
      if (capture) begin
        if (capture_exc) begin
          wb_rd_q   <= 5'(RSTATUS_REG);
          wb_data_q <= op_is_mult_q ? EXC_CODE_MULT : EXC_CODE_DIV;
        end else begin
          wb_rd_q   <= rd_q;
          wb_data_q <= data_result;
        end
      end
    end
  end

  assign stall    = (state_q != IDLE) || in_valid;
  assign md_opA   = op_a_q;
  assign md_opB   = op_b_q;
  assign wb_valid = (state_q == WB);
  assign wb_rd    = wb_valid ? wb_rd_q : 5'd0;
  assign wb_data  = wb_valid ? wb_data_q : 32'd0;

endmodule

// File: tb/tb_multdiv_issue.sv
// Self-checking bench for multdiv_issue: directed cases plus randomized ops against a writeback model.
module tb_multdiv_issue;

  localparam int TIMEOUT = 40;

  logic        clock = 1'b0;
  logic        clrn;
  logic        in_valid, in_isMult;
  logic [31:0] in_opA, in_opB;
  logic [4:0]  in_rd;
  logic        stall;
  logic [31:0] md_opA, md_opB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;

  int check_cnt   = 0;
  int pass_cnt    = 0;
  int fail_cnt    = 0;
  int mult_pulses = 0;
  int div_pulses  = 0;

  multdiv_issue #(.TIMEOUT_CYCLES(TIMEOUT), .RSTATUS_REG(30)) dut (
    .clock(clock), .clrn(clrn),
    .in_valid(in_valid), .in_isMult(in_isMult), .in_opA(in_opA), .in_opB(in_opB), .in_rd(in_rd),
    .stall(stall), .md_opA(md_opA), .md_opB(md_opB), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception), .data_resultRDY(data_resultRDY),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (ctrl_MULT) mult_pulses++;
    if (ctrl_DIV)  div_pulses++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic is_mult, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd, input logic rdy,
                               input logic [31:0] result, input logic exc, input logic ready);
    @(negedge clock);
    in_valid       = valid;
    in_isMult      = is_mult;
    in_opA         = a;
    in_opB         = b;
    in_rd          = rd;
    data_resultRDY = rdy;
    data_result    = result;
    data_exception = exc;
    wb_ready       = ready;
    #1;
  endtask

  // Architectural outcome of one operation: which register gets written and with what.
  function automatic void refWriteback(input logic is_mult, input logic [4:0] rd,
                                       input logic [31:0] result, input logic exc,
                                       output logic wb, output logic [4:0] wrd,
                                       output logic [31:0] wdata);
    if (exc) begin
      wb = 1'b1; wrd = 5'd30; wdata = is_mult ? 32'd4 : 32'd5;
    end else if (rd == 5'd0) begin
      wb = 1'b0; wrd = 5'd0; wdata = 32'd0;
    end else begin
      wb = 1'b1; wrd = rd; wdata = result;
    end
  endfunction

  task automatic runOp(input string tag, input logic is_mult, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] result,
                       input logic exc, input int rdy_delay, input int ready_delay,
                       input logic timeout_case);
    int m0 = mult_pulses;
    int d0 = div_pulses;
    int wait_idle;
    logic exp_wb;
    logic [4:0] exp_rd;
    logic [31:0] exp_data;
    refWriteback(is_mult, rd, result, exc | timeout_case, exp_wb, exp_rd, exp_data);

    applyStimulus(1'b1, is_mult, a, b, rd, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput({tag, ".req_stall"}, 32'(stall), 32'd1);
    checkOutput({tag, ".req_ctrl"}, 32'({ctrl_MULT, ctrl_DIV}), 32'd0);

    // Held request with other operands and an early RDY must both be ignored here.
    applyStimulus(1'b1, ~is_mult, ~a, ~b, ~rd, 1'b1, $urandom, 1'b1, 1'b0);
    checkOutput({tag, ".issue_mult"}, 32'(ctrl_MULT), 32'(is_mult));
    checkOutput({tag, ".issue_div"}, 32'(ctrl_DIV), 32'(!is_mult));
    checkOutput({tag, ".issue_opA"}, md_opA, a);
    checkOutput({tag, ".issue_opB"}, md_opB, b);
    checkOutput({tag, ".issue_wbv"}, 32'(wb_valid), 32'd0);

    wait_idle = timeout_case ? TIMEOUT - 1 : rdy_delay;
    for (int i = 0; i < wait_idle; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, $urandom, 1'b0, 1'b0);
      checkOutput({tag, ".wait_ctrl"}, 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
      checkOutput({tag, ".wait_opA"}, md_opA, a);
      checkOutput({tag, ".wait_stall"}, 32'(stall), 32'd1);
      checkOutput({tag, ".wait_wbv"}, 32'(wb_valid), 32'd0);
    end

    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, !timeout_case, result, exc, 1'b0);
    checkOutput({tag, ".rdy_stall"}, 32'(stall), 32'd1);
    checkOutput({tag, ".rdy_opB"}, md_opB, b);
    checkOutput({tag, ".rdy_wbv"}, 32'(wb_valid), 32'd0);

    if (exp_wb) begin
      for (int j = 0; j <= ready_delay; j++) begin
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, $urandom, 1'b0, j == ready_delay);
        checkOutput({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
        checkOutput({tag, ".wb_rd"}, 32'(wb_rd), 32'(exp_rd));
        checkOutput({tag, ".wb_data"}, wb_data, exp_data);
        checkOutput({tag, ".wb_stall"}, 32'(stall), 32'd1);
        checkOutput({tag, ".wb_ctrl"}, 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
        checkOutput({tag, ".wb_opA"}, md_opA, a);
      end
    end

    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput({tag, ".done_stall"}, 32'(stall), 32'd0);
    checkOutput({tag, ".done_wbv"}, 32'(wb_valid), 32'd0);
    checkOutput({tag, ".done_wbdata"}, wb_data, 32'd0);
    checkOutput({tag, ".mult_pulses"}, 32'(mult_pulses - m0), 32'(is_mult));
    checkOutput({tag, ".div_pulses"}, 32'(div_pulses - d0), 32'(!is_mult));
  endtask

  initial begin
    logic        r_mult, r_exc;
    logic [31:0] r_a, r_b, r_res;
    logic [4:0]  r_rd;
    int          m0, d0;

    clrn = 1'b0;
    in_valid = 1'b0; in_isMult = 1'b0; in_opA = '0; in_opB = '0; in_rd = '0;
    data_result = '0; data_exception = 1'b0; data_resultRDY = 1'b0; wb_ready = 1'b0;
    #12;
    checkOutput("rst.stall", 32'(stall), 32'd0);
    checkOutput("rst.ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    checkOutput("rst.wbv", 32'(wb_valid), 32'd0);
    checkOutput("rst.wbrd", 32'(wb_rd), 32'd0);
    checkOutput("rst.opA", md_opA, 32'd0);
    in_valid = 1'b1;
    #1;
    checkOutput("rst.stall_valid", 32'(stall), 32'd1);
    in_valid = 1'b0;
    @(negedge clock);
    clrn = 1'b1;

    runOp("mul7xm3", 1'b1, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0, 17, 0, 1'b0);
    runOp("div100by0", 1'b0, 32'd100, 32'd0, 5'd7, 32'd0, 1'b1, 2, 0, 1'b0);
    runOp("mul_ovf", 1'b1, 32'h4000_0000, 32'd4, 5'd3, 32'd0, 1'b1, 1, 1, 1'b0);
    runOp("div9by3_rd0", 1'b0, 32'd9, 32'd3, 5'd0, 32'd3, 1'b0, 3, 0, 1'b0);
    runOp("mul_hold3", 1'b1, 32'd12, 32'd12, 5'd9, 32'd144, 1'b0, 1, 3, 1'b0);
    runOp("div_minlat", 1'b0, 32'd50, 32'd7, 5'd31, 32'd7, 1'b0, 0, 0, 1'b0);
    runOp("exc_rd0", 1'b1, 32'd1, 32'd1, 5'd0, 32'd1, 1'b1, 0, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      r_mult = 1'($urandom);
      r_a    = $urandom;
      r_b    = (($urandom & 3) == 0) ? 32'd0 : $urandom;
      r_rd   = 5'($urandom);
      r_exc  = (($urandom & 3) == 0);
      if (r_mult) begin
        r_res = r_a * r_b;
      end else if (r_b == 32'd0 || (r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF)) begin
        r_exc = 1'b1;
        r_res = $urandom;
      end else begin
        r_res = 32'($signed(r_a) / $signed(r_b));
      end
      runOp("rand", r_mult, r_a, r_b, r_rd, r_res, r_exc,
            int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset while waiting for a divide abandons it completely.
    m0 = mult_pulses;
    d0 = div_pulses;
    applyStimulus(1'b1, 1'b0, 32'd81, 32'd9, 5'd4, 1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("rstmid.pre_stall", 32'(stall), 32'd1);
    @(negedge clock);
    clrn = 1'b0;
    #1;
    checkOutput("rstmid.stall", 32'(stall), 32'd0);
    checkOutput("rstmid.opA", md_opA, 32'd0);
    checkOutput("rstmid.opB", md_opB, 32'd0);
    checkOutput("rstmid.wbv", 32'(wb_valid), 32'd0);
    checkOutput("rstmid.wbdata", wb_data, 32'd0);
    @(negedge clock);
    clrn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 32'd9, 1'b0, 1'b1);
      checkOutput("rstmid.late_wbv", 32'(wb_valid), 32'd0);
      checkOutput("rstmid.late_stall", 32'(stall), 32'd0);
    end
    checkOutput("rstmid.div_pulses", 32'(div_pulses - d0), 32'd1);
    checkOutput("rstmid.mult_pulses", 32'(mult_pulses - m0), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);

`ifdef MD_TIMEOUT_EN
    runOp("timeout", 1'b0, 32'd5, 32'd1, 5'd6, 32'd5, 1'b0, 0, 0, 1'b1);
    runOp("rdy_at_limit", 1'b1, 32'd6, 32'd6, 5'd6, 32'd36, 1'b0, TIMEOUT - 1, 0, 1'b0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
